icache_dm: RTL

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm.sv | 102 ++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per frame, blocking
// two-state fill FSM and saturating hit/miss counters.
module icache_dm #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              fill;
    logic              unused_ok;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];
    assign unused_ok = ^{imemaddr[1:0], miss_addr_q[1:0]};

    // Outputs are forced quiet while RST is high, whatever the state.
    assign ihit     = !RST && (state_q == IDLE) && imemREN
                      && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign imemload = ihit ? data_q[req_idx] : 32'd0;
    assign iREN     = !RST && (state_q == MISS);
    assign iaddr    = iREN ? miss_addr_q : 32'd0;
    assign fill     = iREN && !iwait;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (ihit) begin
                    if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                end else if (imemREN) begin
                    miss_addr_d = imemaddr;
                    state_d     = MISS;
                end
            end
            MISS: begin
                if (!iwait) begin
                    valid_d[fill_idx] = 1'b1;
                    if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'd0;
            valid_q     <= '0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end
endmodule
